// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the byte-sequenced data-memory controller.
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEAT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int BEAT_W         = 2;
    localparam int WAIT_W         = 3;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BYTES_PER_WORD - 1);

    // Little-endian byte lane of a word: lane 0 is bits [7:0].
    function automatic logic [7:0] lane_of(input logic [31:0]       word,
                                           input logic [BEAT_W-1:0] lane);
        return word[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/dmem_beat_timer.sv
// Beat/wait counters: each byte beat lasts 1+BEAT_WAIT cycles, four beats per word.
module dmem_beat_timer
    import dmem_ctrl_pkg::*;
#(
    parameter int BEAT_WAIT = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              run_i,
    output logic [BEAT_W-1:0] beat_o,
    output logic              beat_last_o,
    output logic              word_last_o
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BEAT_WAIT);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [BEAT_W-1:0] beat_q, beat_d;

    assign beat_o      = beat_q;
    assign beat_last_o = run_i && (wait_q == WAIT_LAST);
    assign word_last_o = beat_last_o && (beat_q == LAST_BEAT);

    // Advance wait then beat while running; park both at zero otherwise.
    always_comb begin
        // NOTE: defaults assigned first so every path drives every output and no latch is inferred.
        wait_d = '0;
        beat_d = '0;
        if (run_i) begin
            if (beat_last_o) begin
                wait_d = '0;
                beat_d = beat_q + 1'b1;  // beat 3 wraps to 0 exactly when the FSM leaves BEAT
            end else begin
                wait_d = wait_q + 1'b1;
                beat_d = beat_q;
            end
        end
    end

    // Counter registers, synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (!rst_i) begin
            wait_q <= '0;
            beat_q <= '0;
        end else begin
            wait_q <= wait_d;
            beat_q <= beat_d;
        end
    end

endmodule

// File: rtl/dmem_byte_seq_ctrl.sv
// Splits 32-bit MEM-stage loads/stores into four little-endian byte beats,
// stalling the pipeline until the word is complete.
module dmem_byte_seq_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int BEAT_WAIT = 0,
    parameter int AW        = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          memread_i,
    input  logic          memwrite_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o,
    output logic          stall_o,
    output logic          done_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [7:0]    mem_wdata_o,
    output logic          mem_read_o,
    output logic          mem_write_o,
    input  logic [7:0]    mem_rdata_i
);

    state_e        state_q, state_d;
    logic          is_write_q, is_write_d;  // store (also set when read+write both requested)
    logic          raw_q, raw_d;            // read+write: load result is the store data
    logic [AW-1:0] base_q, base_d;          // word-aligned base address
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rbuf_q, rbuf_d;          // bytes gathered during a load
    logic [31:0]   rdata_q, rdata_d;

    logic [BEAT_W-1:0] beat;
    logic              beat_last;
    logic              word_last;
    logic              in_beat;
    logic              req;

    assign req     = memread_i | memwrite_i;
    assign in_beat = (state_q == BEAT);

    dmem_beat_timer #(
        .BEAT_WAIT (BEAT_WAIT)
    ) u_timer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .run_i       (in_beat),
        .beat_o      (beat),
        .beat_last_o (beat_last),
        .word_last_o (word_last)
    );

    // Next-state logic: latch the request in IDLE, gather bytes in BEAT, publish at DONE.
    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        raw_d      = raw_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        rbuf_d     = rbuf_q;
        rdata_d    = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    is_write_d = memwrite_i;
                    raw_d      = memread_i & memwrite_i;
                    base_d     = addr_i & ~AW'(3);
                    wdata_d    = wdata_i;
                    state_d    = BEAT;
                end
            end
            BEAT: begin
                if (beat_last && !is_write_q) begin
                    rbuf_d[{beat, 3'b000} +: 8] = mem_rdata_i;
                end
                if (word_last) begin
                    state_d = DONE;
                    // Load the result on entry to DONE so it is visible while done_o is high.
                    if (raw_q) begin
                        rdata_d = wdata_q;
                    end else if (!is_write_q) begin
                        rdata_d = rbuf_d;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller registers, synchronous active-low reset; reset abandons any access.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            is_write_q <= 1'b0;
            raw_q      <= 1'b0;
            base_q     <= '0;
            wdata_q    <= '0;
            rbuf_q     <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            raw_q      <= raw_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            rbuf_q     <= rbuf_d;
            rdata_q    <= rdata_d;
        end
    end

    // Memory-side outputs decode from registered state; all zero outside BEAT.
    assign mem_addr_o  = in_beat ? (base_q | AW'(beat)) : '0;
    assign mem_wdata_o = (in_beat && is_write_q) ? lane_of(wdata_q, beat) : 8'h00;
    assign mem_read_o  = beat_last && !is_write_q;
    assign mem_write_o = beat_last && is_write_q;

    assign stall_o = in_beat || ((state_q == IDLE) && req);
    assign done_o  = (state_q == DONE);
    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_dmem_byte_seq_ctrl.sv
// Bench: two controllers (BEAT_WAIT 0 and 2), each on its own byte memory,
// checked against a word-level reference model of memory and load results.
module tb_dmem_byte_seq_ctrl;

    localparam int AW = 32;
    localparam int W0 = 0;
    localparam int W1 = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        memread  [2];
    logic        memwrite [2];
    logic [31:0] addr     [2];
    logic [31:0] wdata    [2];
    logic [31:0] rdata    [2];
    logic        stall    [2];
    logic        done     [2];
    logic [31:0] mem_addr [2];
    logic [7:0]  mem_wdata[2];
    logic        mem_read [2];
    logic        mem_write[2];
    logic [7:0]  mem_rdata[2];

    logic [7:0]  mem     [2][256] = '{default: 8'h00};
    logic [7:0]  ref_mem [2][256] = '{default: 8'h00};
    logic [31:0] exp_rdata[2]     = '{default: 32'h0};

    int checks   = 0;
    int failures = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dmem_byte_seq_ctrl #(
            .BEAT_WAIT ((g == 0) ? W0 : W1),
            .AW        (AW)
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .memread_i   (memread[g]),
            .memwrite_i  (memwrite[g]),
            .addr_i      (addr[g]),
            .wdata_i     (wdata[g]),
            .rdata_o     (rdata[g]),
            .stall_o     (stall[g]),
            .done_o      (done[g]),
            .mem_addr_o  (mem_addr[g]),
            .mem_wdata_o (mem_wdata[g]),
            .mem_read_o  (mem_read[g]),
            .mem_write_o (mem_write[g]),
            .mem_rdata_i (mem_rdata[g])
        );
        assign mem_rdata[g] = mem[g][mem_addr[g][7:0]];
    end

    // Byte memories behind the controllers (addresses alias on the low 8 bits).
    always @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (mem_write[s]) mem[s][mem_addr[s][7:0]] <= mem_wdata[s];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input int s, input logic [31:0] base);
        logic [31:0] w = '0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = mem[s][(base + i) % 256];
        return w;
    endfunction

    function automatic logic [31:0] ref_word(input int s, input logic [31:0] base);
        logic [31:0] w = 0;
        for (int i = 0; i < 4; i++) w = w + (32'(ref_mem[s][(base + i) % 256]) << (8 * i));
        return w;
    endfunction

    // One complete access, starting on a falling edge while the controller idles.
    // Returns on the falling edge of the IDLE cycle that follows DONE.
    task automatic access(input int s, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] wd, input string tag);
        int          per = 1 + ((s == 0) ? W0 : W1);
        int          n_stall = 0;
        int          n_strobe = 0;
        int          bad = 0;
        int          t_done = -1;
        int          lane;
        logic        done_stall = 1'b1;
        logic [31:0] base = a - (a % 4);

        if (wr) begin
            for (int i = 0; i < 4; i++) ref_mem[s][(base + i) % 256] = 8'((wd >> (8 * i)) & 32'hFF);
            if (rd) exp_rdata[s] = wd;
        end else begin
            exp_rdata[s] = ref_word(s, base);
        end

        memread[s]  = rd;
        memwrite[s] = wr;
        addr[s]     = a;
        wdata[s]    = wd;
        for (int t = 0; t < 200; t++) begin
            #1;
            if (done[s]) begin
                t_done     = t;
                done_stall = stall[s];
                break;
            end
            if (stall[s]) n_stall++;
            if (mem_read[s] || mem_write[s]) begin
                n_strobe++;
                lane = t / per - 1;
                if (t == 0 || (t % per) != 0 || lane > 3) bad++;
                else if (mem_read[s] && mem_write[s]) bad++;
                else if (mem_addr[s] !== base + lane) bad++;
                else if (wr && !(mem_write[s] && mem_wdata[s] === 8'((wd >> (8 * lane)) & 32'hFF))) bad++;
                else if (!wr && !mem_read[s]) bad++;
            end
            @(negedge clk);
        end
        memread[s]  = 1'b0;
        memwrite[s] = 1'b0;

        check({tag, "/done_cycle"}, t_done, 1 + 4 * per);
        check({tag, "/stall_cycles"}, n_stall, 1 + 4 * per);
        check({tag, "/stall_in_done"}, done_stall, 0);
        check({tag, "/strobes"}, n_strobe, 4);
        check({tag, "/strobe_pattern"}, bad, 0);
        check({tag, "/rdata"}, rdata[s], exp_rdata[s]);
        if (wr) check({tag, "/mem_word"}, mem_word(s, base), ref_word(s, base));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before the bench finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          s;
        int          op;
        logic [31:0] a;

        for (int i = 0; i < 2; i++) begin
            memread[i]  = 1'b0;
            memwrite[i] = 1'b0;
            addr[i]     = '0;
            wdata[i]    = '0;
        end

        // Reset state
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset%0d/ctl", i), {28'h0, stall[i], done[i], mem_read[i], mem_write[i]}, 32'h0);
            check($sformatf("reset%0d/rdata", i), rdata[i], 32'h0);
            check($sformatf("reset%0d/mem_addr", i), mem_addr[i], 32'h0);
            check($sformatf("reset%0d/mem_wdata", i), {24'h0, mem_wdata[i]}, 32'h0);
        end
        rst = 1'b1;
        @(negedge clk);

        // Directed: store, load, unaligned load, store leaves rdata alone
        access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "wr_10");
        check("wr_10/bytes", mem_word(0, 32'h10), 32'hDEADBEEF);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, "rd_10");
        check("rd_10/value", rdata[0], 32'hDEADBEEF);
        access(0, 1'b1, 1'b0, 32'h13, 32'h0, "rd_13");
        check("rd_13/value", rdata[0], 32'hDEADBEEF);
        access(0, 1'b0, 1'b1, 32'h50, 32'hCAFEF00D, "wr_50_hold");
        check("wr_50_hold/value", rdata[0], 32'hDEADBEEF);

        // Slow memory: three cycles per beat
        access(1, 1'b0, 1'b1, 32'h20, 32'h01020304, "w2_wr_20");
        check("w2_wr_20/bytes", mem_word(1, 32'h20), 32'h01020304);
        access(1, 1'b1, 1'b0, 32'h22, 32'h0, "w2_rd_22");
        check("w2_rd_22/value", rdata[1], 32'h01020304);

        // Reset during the second beat of a store
        memwrite[0] = 1'b1;
        addr[0]     = 32'h30;
        wdata[0]    = 32'hAABBCCDD;
        @(negedge clk);
        @(negedge clk);
        rst         = 1'b0;
        memwrite[0] = 1'b0;
        @(negedge clk);
        #1;
        check("rst_mid/ctl", {28'h0, stall[0], done[0], mem_read[0], mem_write[0]}, 32'h0);
        check("rst_mid/rdata", rdata[0], 32'h0);
        check("rst_mid/mem_addr", mem_addr[0], 32'h0);
        check("rst_mid/mem_wdata", {24'h0, mem_wdata[0]}, 32'h0);
        check("rst_mid/bytes", mem_word(0, 32'h30), 32'h0000CCDD);
        rst = 1'b1;
        ref_mem[0][8'h30] = 8'hDD;
        ref_mem[0][8'h31] = 8'hCC;
        exp_rdata[0] = 32'h0;
        exp_rdata[1] = 32'h0;
        @(negedge clk);

        // Read+write together, then an immediate back-to-back read
        access(0, 1'b1, 1'b1, 32'h40, 32'h12345678, "rw_40");
        check("rw_40/value", rdata[0], 32'h12345678);
        access(0, 1'b1, 1'b0, 32'h40, 32'h0, "b2b_rd_40");
        check("b2b_rd_40/value", rdata[0], 32'h12345678);

        // Randomized traffic on both controllers
        for (int n = 0; n < 40; n++) begin
            s  = int'($urandom_range(0, 1));
            op = int'($urandom_range(0, 3));
            a  = $urandom();
            if ((n % 3) == 0) a = {a[31:4], 4'h0} | 32'h1;
            access(s, op != 1, op != 0, a, $urandom(), $sformatf("rnd%0d_s%0d_op%0d", n, s, op));
            repeat ($urandom_range(0, 2)) begin
                #1;
                check($sformatf("rnd%0d/idle_ctl", n), {30'h0, stall[s], done[s]}, 32'h0);
                @(negedge clk);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
